// File: rtl/instr_encoder_pkg.sv
// Shared instruction-word layout, FSM states and bus payload types for the
// instruction encoder; the decoder uses the same constants.
package instr_encoder_pkg;

   localparam int unsigned WORD_W   = 32;
   localparam int unsigned BYTE_W   = 8;
   localparam int unsigned OPCODE_W = 8;
   localparam int unsigned REG_W    = 3;
   localparam int unsigned IMM_W    = 8;

   // Field bit positions inside the 32-bit instruction word
   localparam int unsigned OPCODE_MSB = 31;
   localparam int unsigned OPCODE_LSB = 24;
   localparam int unsigned DEST_MSB   = 18;
   localparam int unsigned DEST_LSB   = 16;
   localparam int unsigned SRC1_MSB   = 10;
   localparam int unsigned SRC1_LSB   = 8;
   localparam int unsigned OPND_MSB   = 7;   // SRC2 or IMM
   localparam int unsigned OPND_LSB   = 0;

   // Encoder FSM states
   typedef logic [0:0] state_t;
   localparam state_t ST_IDLE  = 1'b0;
   localparam state_t ST_WRITE = 1'b1;

   // Assembler-level field tuple
   typedef struct packed {
      logic [OPCODE_W-1:0] opcode;
      logic [REG_W-1:0]    dest;
      logic [REG_W-1:0]    src1;
      logic [REG_W-1:0]    src2;
      logic [IMM_W-1:0]    imm;
      logic                use_imm;
   } fields_t;

   // Little-endian byte lane select
   function automatic logic [BYTE_W-1:0] byte_of(input logic [WORD_W-1:0] w,
                                                 input logic [1:0]        idx);
      logic [BYTE_W-1:0] b;
      case (idx)
         2'd0:    b = w[7:0];
         2'd1:    b = w[15:8];
         2'd2:    b = w[23:16];
         default: b = w[31:24];
      endcase
      return b;
   endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Field-tuple handshake plus instruction-memory byte write port.
interface instr_encoder_if
   import instr_encoder_pkg::*;
#(
   parameter int unsigned ADDR_W = 10
);
   logic                in_valid;
   logic                in_ready;
   logic [OPCODE_W-1:0] opcode;
   logic [REG_W-1:0]    dest;
   logic [REG_W-1:0]    src1;
   logic [REG_W-1:0]    src2;
   logic [IMM_W-1:0]    imm;
   logic                use_imm;
   logic                addr_load;
   logic [ADDR_W-1:0]   addr_in;
   logic                mem_write;
   logic [ADDR_W-1:0]   mem_addr;
   logic [BYTE_W-1:0]   mem_writedata;
   logic                mem_busywait;
   logic                word_done;
   logic                wrapped;

   // Program source and memory side
   modport master (
      output in_valid, opcode, dest, src1, src2, imm, use_imm,
             addr_load, addr_in, mem_busywait,
      input  in_ready, mem_write, mem_addr, mem_writedata, word_done, wrapped
   );

   // Encoder side
   modport slave (
      input  in_valid, opcode, dest, src1, src2, imm, use_imm,
             addr_load, addr_in, mem_busywait,
      output in_ready, mem_write, mem_addr, mem_writedata, word_done, wrapped
   );

endinterface

// File: rtl/instr_pack.sv
// Combinational packing of a field tuple into the 32-bit instruction word.
module instr_pack
   import instr_encoder_pkg::*;
(
   input  fields_t           fields,
   output logic [WORD_W-1:0] word_c
);

   // Reserved bits stay zero; low byte is IMM or zero-extended SRC2
   always_comb begin
      word_c = '0;
      word_c[OPCODE_MSB:OPCODE_LSB] = fields.opcode;
      word_c[DEST_MSB:DEST_LSB]     = fields.dest;
      word_c[SRC1_MSB:SRC1_LSB]     = fields.src1;
      word_c[OPND_MSB:OPND_LSB]     = fields.use_imm ? fields.imm
                                                     : IMM_W'(fields.src2);
   end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: accepts field tuples, packs them and writes the word
// little-endian, one byte per completed memory cycle, at a wrapping pointer.
module instr_encoder
   import instr_encoder_pkg::*;
#(
   parameter int unsigned ADDR_W = 10
) (
   input logic            clk,
   input logic            reset,
   instr_encoder_if.slave bus
);

   localparam int unsigned SUM_W = ADDR_W + 1;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   ptr_q, ptr_d;
   logic [1:0]          k_q, k_d;
   logic [WORD_W-1:0]   word_q, word_d;
   logic                wr_q, wr_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [BYTE_W-1:0]   data_q, data_d;
   logic                done_q, done_d;
   logic                wrap_q, wrap_d;

   fields_t             fields_c;
   logic [WORD_W-1:0]   pack_word_c;
   logic [SUM_W-1:0]    ptr_sum_c;
   logic                in_ready_c;

   // Gather the tuple fields into the payload struct
   always_comb begin
      fields_c         = '0;
      fields_c.opcode  = bus.opcode;
      fields_c.dest    = bus.dest;
      fields_c.src1    = bus.src1;
      fields_c.src2    = bus.src2;
      fields_c.imm     = bus.imm;
      fields_c.use_imm = bus.use_imm;
   end

   instr_pack u_pack (
      .fields (fields_c),
      .word_c (pack_word_c)
   );

   // Pointer advance with carry out for wrap detection
   assign ptr_sum_c  = {1'b0, ptr_q} + SUM_W'(4);

   // Pointer load has priority over tuple acceptance
   assign in_ready_c = (state_q == ST_IDLE) && !bus.addr_load;

   // Next-state and next-output logic
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      k_d     = k_q;
      word_d  = word_q;
      wr_d    = wr_q;
      addr_d  = addr_q;
      data_d  = data_q;
      done_d  = 1'b0;
      wrap_d  = wrap_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.addr_load) begin
               ptr_d = bus.addr_in;
            end else if (bus.in_valid) begin
               state_d = ST_WRITE;
               word_d  = pack_word_c;
               k_d     = 2'd0;
               wr_d    = 1'b1;
               addr_d  = ptr_q;
               data_d  = byte_of(pack_word_c, 2'd0);
            end
         end
         ST_WRITE: begin
            if (!bus.mem_busywait) begin
               if (k_q == 2'd3) begin
                  state_d = ST_IDLE;
                  wr_d    = 1'b0;
                  ptr_d   = ptr_sum_c[ADDR_W-1:0];
                  done_d  = 1'b1;
                  wrap_d  = wrap_q | ptr_sum_c[ADDR_W];
               end else begin
                  k_d    = k_q + 2'd1;
                  addr_d = ptr_q + ADDR_W'(k_d);
                  data_d = byte_of(word_q, k_d);
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State, pointer and registered outputs; reset aborts any word in flight
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         ptr_q   <= '0;
         k_q     <= '0;
         word_q  <= '0;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
         done_q  <= 1'b0;
         wrap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         k_q     <= k_d;
         word_q  <= word_d;
         wr_q    <= wr_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         done_q  <= done_d;
         wrap_q  <= wrap_d;
      end
   end

   assign bus.in_ready      = in_ready_c;
   assign bus.mem_write     = wr_q;
   assign bus.mem_addr      = addr_q;
   assign bus.mem_writedata = data_q;
   assign bus.word_done     = done_q;
   assign bus.wrapped       = wrap_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: directed cases plus random tuples,
// checked against a word-level model of the byte writes.
module tb_instr_encoder;
   import instr_encoder_pkg::*;

   localparam int unsigned AW    = 4;
   localparam int          ASIZE = 1 << AW;

   typedef struct {
      int addr;
      int data;
   } bexp_t;

   typedef struct {
      int acc;
      int wrapped;
   } wexp_t;

   logic clk = 1'b0;
   logic reset = 1'b0;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;

   bexp_t bq[$];
   wexp_t wq[$];
   int    m_ptr = 0;
   int    m_wrapped = 0;
   int    stalls = 0;
   int    last_done = -1;
   bit    prev_stall = 1'b0;
   int    prev_addr = 0;
   int    prev_data = 0;
   bit    busy_rand = 1'b0;
   bit    busy_force = 1'b0;

   instr_encoder_if #(.ADDR_W(AW)) bus ();

   instr_encoder #(.ADDR_W(AW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   // Memory stall generator
   always @(posedge clk) begin
      #1;
      bus.mem_busywait = busy_rand ? ($urandom_range(0, 3) == 0) : busy_force;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: whole word, four little-endian bytes at ptr..ptr+3 mod 2^AW
   task automatic model_push(input int opc, input int dest, input int s1, input int s2,
                             input int imm, input int ui, input int acc);
      int unsigned w;
      w = (opc << 24) + (dest << 16) + (s1 << 8) + (ui != 0 ? imm : s2);
      for (int k = 0; k < 4; k++)
         bq.push_back('{(m_ptr + k) % ASIZE, int'((w >> (8 * k)) & 32'hFF)});
      if (m_ptr + 4 >= ASIZE) m_wrapped = 1;
      m_ptr = (m_ptr + 4) % ASIZE;
      wq.push_back('{acc, m_wrapped});
   endtask

   task automatic scramble();
      bus.opcode  = 8'($urandom);
      bus.dest    = 3'($urandom);
      bus.src1    = 3'($urandom);
      bus.src2    = 3'($urandom);
      bus.imm     = 8'($urandom);
      bus.use_imm = 1'($urandom);
   endtask

   task automatic send(input int opc, input int dest, input int s1, input int s2,
                       input int imm, input int ui, output int acc);
      int n;
      n = 0;
      acc = -1;
      bus.opcode  = 8'(opc);
      bus.dest    = 3'(dest);
      bus.src1    = 3'(s1);
      bus.src2    = 3'(s2);
      bus.imm     = 8'(imm);
      bus.use_imm = 1'(ui);
      bus.in_valid = 1'b1;
      @(negedge clk);
      while (!bus.in_ready) begin
         n++;
         if (n > 100) begin
            check("accept_timeout", 32'd0, 32'd1);
            bus.in_valid = 1'b0;
            return;
         end
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      acc = cyc;
      bus.in_valid = 1'b0;
      scramble();
      model_push(opc, dest, s1, s2, imm, ui, acc);
   endtask

   task automatic send_rand(output int acc);
      send(int'($urandom_range(0, 255)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
           int'($urandom_range(0, 7)), int'($urandom_range(0, 255)), int'($urandom_range(0, 1)), acc);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((bq.size() != 0 || wq.size() != 0) && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) check("drain_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
   endtask

   task automatic load(input int a, input bit with_valid, output int edge_n);
      bus.addr_load = 1'b1;
      bus.addr_in   = AW'(a);
      bus.in_valid  = with_valid;
      @(negedge clk);
      check("ready_during_load", 32'(bus.in_ready), 32'd0);
      @(posedge clk);
      #1;
      edge_n = cyc;
      bus.addr_load = 1'b0;
      m_ptr = a;
   endtask

   // Monitor: pops expected bytes and word completions as the DUT presents them
   always @(negedge clk) begin
      if (reset) begin
         if (prev_stall) begin
            check("stall_hold_write", 32'(bus.mem_write), 32'd1);
            check("stall_hold_addr", 32'(bus.mem_addr), 32'(prev_addr));
            check("stall_hold_data", 32'(bus.mem_writedata), 32'(prev_data));
         end
         prev_stall = bus.mem_write && bus.mem_busywait;
         prev_addr  = int'(bus.mem_addr);
         prev_data  = int'(bus.mem_writedata);
         if (bus.mem_write && bus.mem_busywait) stalls++;
         if (bus.mem_write && !bus.mem_busywait) begin
            if (bq.size() == 0) begin
               check("unexpected_byte", 32'd1, 32'd0);
            end else begin
               bexp_t e;
               e = bq.pop_front();
               check("byte_addr", 32'(bus.mem_addr), 32'(e.addr));
               check("byte_data", 32'(bus.mem_writedata), 32'(e.data));
            end
         end
         if (bus.word_done) begin
            if (wq.size() == 0) begin
               check("unexpected_word_done", 32'd1, 32'd0);
            end else begin
               wexp_t w;
               w = wq.pop_front();
               check("bytes_before_done", 32'(bq.size()), 32'(4 * wq.size()));
               check("wrapped", 32'(bus.wrapped), 32'(w.wrapped));
               check("done_latency", 32'(cyc), 32'(w.acc + 4 + stalls));
            end
            last_done = cyc;
            stalls = 0;
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, total=%0d", total);
      $fatal(1);
   end

   initial begin
      int a1, a2, e;
      bus.in_valid     = 1'b0;
      bus.addr_load    = 1'b0;
      bus.addr_in      = '0;
      bus.mem_busywait = 1'b0;
      scramble();

      // Reset values
      repeat (3) @(posedge clk);
      #1;
      check("rst_mem_write", 32'(bus.mem_write), 32'd0);
      @(negedge clk);
      #2 reset = 1'b1;
      @(posedge clk);
      #1;
      check("rst_in_ready", 32'(bus.in_ready), 32'd1);
      check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
      check("rst_mem_data", 32'(bus.mem_writedata), 32'd0);
      check("rst_word_done", 32'(bus.word_done), 32'd0);
      check("rst_wrapped", 32'(bus.wrapped), 32'd0);

      // Immediate word at pointer 0: 0x0004002A
      send(8'h00, 4, 0, 0, 8'h2A, 1, a1);
      wait_idle();
      check("t1_done_cycle", 32'(last_done - a1), 32'd4);

      // Register word 0x02010203 followed back-to-back by another tuple
      send(8'h02, 1, 2, 3, 8'hFF, 0, a1);
      send_rand(a2);
      check("back_to_back_gap", 32'(a2 - a1), 32'd5);
      wait_idle();

      // Wrap across the top of the address space: 14,15,0,1
      load(14, 1'b0, e);
      send_rand(a1);
      wait_idle();
      check("wrap_flag", 32'(bus.wrapped), 32'd1);

      // Three stall cycles during byte 2
      send_rand(a1);
      @(posedge clk);
      #2 busy_force = 1'b1;
      repeat (3) @(posedge clk);
      #2 busy_force = 1'b0;
      wait_idle();
      check("stall_done_cycle", 32'(last_done - a1), 32'd7);

      // Load and tuple offered together: load wins, tuple taken next edge
      load(5, 1'b1, e);
      send_rand(a1);
      check("load_then_accept", 32'(a1), 32'(e + 1));
      wait_idle();

      // Random tuples with random stalls and occasional pointer loads
      busy_rand = 1'b1;
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 5) == 0) begin
            wait_idle();
            load(int'($urandom_range(0, ASIZE - 1)), 1'b0, e);
         end
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #1;
         send_rand(a1);
      end
      wait_idle();
      busy_rand = 1'b0;
      busy_force = 1'b0;
      @(posedge clk);
      #1;

      // Reset during byte 1 aborts the word
      send_rand(a1);
      @(posedge clk);
      #2 reset = 1'b0;
      #1;
      check("abort_mem_write", 32'(bus.mem_write), 32'd0);
      bq.delete();
      wq.delete();
      stalls = 0;
      prev_stall = 1'b0;
      m_ptr = 0;
      m_wrapped = 0;
      @(negedge clk);
      #2 reset = 1'b1;
      @(posedge clk);
      #1;
      check("post_rst_ready", 32'(bus.in_ready), 32'd1);
      check("post_rst_wrapped", 32'(bus.wrapped), 32'd0);
      check("post_rst_mem_write", 32'(bus.mem_write), 32'd0);
      send_rand(a1);
      wait_idle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Packs assembler-level instruction fields into the processor's 32-bit instruction word and writes it, byte by byte, into the byte-addressed instruction memory. It is the write-side counterpart of the instruction decoder: it produces exactly the field layout that the decoder extracts. It sits between a program source (boot loader or testbench driver) and the instruction memory's write port.

## Interface
- `ADDR_W`, default 10: instruction-memory byte-address width; the address wraps modulo 2^ADDR_W.
- `CLK`  in  1: single clock, rising edge.
- `RESET`  in  1: asynchronous, active-low reset.
- `IN_VALID`  in  1: field tuple valid.
- `IN_READY`  out  1: block can accept a tuple.
- `OPCODE`  in  8: opcode field.
- `DEST`  in  3: destination register.
- `SRC1`  in  3: source-1 register.
- `SRC2`  in  3: source-2 register.
- `IMM`  in  8: immediate value.
- `USE_IMM`  in  1: selects `IMM`, not `SRC2`, for word bits [7:0].
- `ADDR_LOAD`  in  1: load the write pointer from `ADDR_IN`.
- `ADDR_IN`  in  ADDR_W: new write pointer.
- `MEM_WRITE`  out  1: memory byte-write strobe.
- `MEM_ADDR`  out  ADDR_W: byte address.
- `MEM_WRITEDATA`  out  8: byte data.
- `MEM_BUSYWAIT`  in  1: memory stall.
- `WORD_DONE`  out  1: one-cycle pulse when all four bytes of a word are written.
- `WRAPPED`  out  1: sticky flag; the write pointer has wrapped past 2^ADDR_W-1.

## Operation

**Word format:**
- [31:24] = `OPCODE`
- [23:19] = 0
- [18:16] = `DEST`
- [15:11] = 0
- [10:8] = `SRC1`
- [7:0] = `USE_IMM` ? `IMM` : {5'b0, `SRC2`}

**Byte order:** little-endian. Byte k = word[8k+7:8k] is written to pointer+k, for k = 0..3.

**State machine:**
- IDLE:
  - `IN_READY` = !`ADDR_LOAD`.
  - `ADDR_LOAD`=1 loads the pointer. Load has priority: a tuple offered in the same cycle is not accepted.
  - `IN_VALID` & `IN_READY` latches the packed word, clears byte index k, and goes to WRITE.
- WRITE:
  - `MEM_WRITE`=1, `MEM_ADDR` = pointer+k, `MEM_WRITEDATA` = byte k.
  - A byte completes on a rising edge with `MEM_BUSYWAIT`=0, which increments k.
  - When k=3 completes: pointer += 4, `WORD_DONE` pulses, return to IDLE.
  - `ADDR_LOAD` is ignored outside IDLE.
- While `MEM_BUSYWAIT`=1, all memory outputs hold stable.

**Wrap:**
- Pointer and `MEM_ADDR` arithmetic is modulo 2^ADDR_W; bytes in a single word may straddle the wrap.
- `WRAPPED` sets on the edge where pointer+4 overflows, and clears only on reset.

**Reset:**
- Asserting `RESET` mid-word aborts immediately (asynchronously): `MEM_WRITE` drops at once.
- A partially written word is not resumed.

**Reset values:** state=IDLE, pointer=0, `IN_READY`=1 (combinational, with `ADDR_LOAD`=0), `MEM_WRITE`=0, `MEM_ADDR`=0, `MEM_WRITEDATA`=0, `WORD_DONE`=0, `WRAPPED`=0.

## Timing
- All outputs except `IN_READY` are registered.
- Tuple accepted at edge N → byte 0 is presented in cycle N+1. With no stalls, bytes are written at edges N+1..N+4.
- `WORD_DONE` is high in the cycle after edge N+4. `IN_READY` returns in that same cycle, so the next accept is at edge N+5 at the earliest.
- Throughput: 5 cycles per word without stalls. Each stall cycle adds one.
- Field inputs are sampled only at the accept edge and may change afterwards.

## Structure
- Shared package: field bit positions (OPCODE_MSB/LSB = 31/24, DEST 18:16, SRC1 10:8, SRC2/IMM 7:0), register-address width 3, opcode width 8, and the state enum. The decoder uses the same constants, so the encode and decode layouts cannot drift.
- One combinational sub-module, `instr_pack`: fields → 32-bit word.
- The FSM, pointer and byte mux live in `instr_encoder`.

## Test plan
- OPCODE=8'h00, DEST=4, IMM=8'h2A, USE_IMM=1, pointer 0 → word 0x0004002A; bytes 2A,00,04,00 written at addresses 0..3; `WORD_DONE` at cycle 5; pointer=4.
- OPCODE=8'h02, DEST=1, SRC1=2, SRC2=3, USE_IMM=0 → word 0x02010203; bytes 03,02,01,02. Then a back-to-back second tuple is accepted exactly 5 cycles after the first.
- `MEM_BUSYWAIT` high for 3 cycles during byte 2 → `MEM_ADDR`/`MEM_WRITEDATA` held; `WORD_DONE` delayed to cycle 8.
- ADDR_W=4, `ADDR_LOAD` with ADDR_IN=14, then one word → bytes at 14, 15, 0, 1; `WRAPPED`=1; pointer=2.
- `ADDR_LOAD`=1 with `IN_VALID`=1 in the same cycle → `IN_READY`=0, pointer loaded, tuple accepted on the next edge at the new address.
- `RESET` low during byte 1 → `MEM_WRITE`=0 immediately; after release the block is in IDLE with pointer=0, and a new tuple writes from address 0.
